btn_cond: RTL and testbench

- Input-side conditioner for the calculator's push-buttons. It synchronises the five raw, bouncing board buttons into the clock domain.
- Each button is debounced independently by a counter-based state machine.
- Outputs per button: a clean stable level, plus a single-cycle press pulse.
- The pulses drive the calculator's btnc/btnl/btnu/btnr/btnd inputs, so each physical press causes exactly one accumulator update.

---
 rtl/btn_cond.sv | 118 +++++++++++
 tb/tb_btn_cond.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_cond.sv
// Push-button conditioner: two-flop synchroniser plus an independent
// counter-based debounce FSM per button, producing level, press and release.
module btn_cond #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [N_BTN-1:0] btn_release
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] s1_q;
    logic [N_BTN-1:0] s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s_q  <= '0;
        end else begin
            s1_q <= btn_raw;
            s_q  <= s1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             level_q, level_d;
            logic             pulse_q, pulse_d;
            logic             release_q, release_d;

            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                level_d   = level_q;
                pulse_d   = 1'b0;
                release_d = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (s_q[gi]) begin
                            state_d = PRESS_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    PRESS_WAIT: begin
                        // Any low sample throws away the partial qualification.
                        if (!s_q[gi]) begin
                            state_d = IDLE;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = PRESSED;
                            level_d = 1'b1;
                            pulse_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!s_q[gi]) begin
                            state_d = RELEASE_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (s_q[gi]) begin
                            state_d = PRESSED;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d   = IDLE;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    level_q   <= 1'b0;
                    pulse_q   <= 1'b0;
                    release_q <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    cnt_q     <= cnt_d;
                    level_q   <= level_d;
                    pulse_q   <= pulse_d;
                    release_q <= release_d;
                end
            end

            assign btn_level[gi]   = level_q;
            assign btn_pulse[gi]   = pulse_q;
            assign btn_release[gi] = release_q;
        end
    endgenerate

endmodule

// File: tb/tb_btn_cond.sv
// Self-checking bench for btn_cond: directed scenarios plus random bouncing,
// compared every cycle against a run-length debounce model.
module tb_btn_cond;

    localparam int N  = 5;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;
    logic [N-1:0] btn_release;

    btn_cond #(.N_BTN(N), .DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_pulse   (btn_pulse),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: raw passes through a two-sample delay, then a button flips its
    // accepted level once DC+1 consecutive samples disagree with it.
    logic [N-1:0] m_s1, m_s, m_level, m_pulse, m_rel;
    int           m_run [N];
    int           pulse_seen [N];
    int           rel_seen [N];

    task automatic model_reset();
        m_s1 = '0; m_s = '0; m_level = '0; m_pulse = '0; m_rel = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] raw);
        m_pulse = '0;
        m_rel   = '0;
        for (int i = 0; i < N; i++) begin
            if (m_s[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DC + 1) begin
                    m_level[i] = m_s[i];
                    if (m_s[i]) m_pulse[i] = 1'b1;
                    else        m_rel[i]   = 1'b1;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s  = m_s1;
        m_s1 = raw;
    endtask

    task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive raw, advance model, compare all outputs 1 ns after the edge.
    task automatic step(input logic [N-1:0] raw);
        btn_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        check_vec("level", btn_level, m_level);
        check_vec("pulse", btn_pulse, m_pulse);
        check_vec("release", btn_release, m_rel);
        check_vec("pulse_rel_overlap", btn_pulse & btn_release, '0);
        for (int i = 0; i < N; i++) begin
            if (btn_pulse[i])   pulse_seen[i]++;
            if (btn_release[i]) rel_seen[i]++;
        end
    endtask

    // Asynchronous reset asserted between edges, held across one edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check_vec("async_rst_level", btn_level, '0);
        check_vec("async_rst_pulse", btn_pulse, '0);
        check_vec("async_rst_release", btn_release, '0);
        @(posedge clk);
        #1;
        model_reset();
        check_vec("rst_level", btn_level, '0);
        rst = 1'b0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            pulse_seen[i] = 0;
            rel_seen[i]   = 0;
        end
    endtask

    int first_edge;
    int hold [N];
    logic [N-1:0] rnd_raw;

    initial begin
        model_reset();
        clear_counts();
        @(negedge clk);
        do_reset();

        // Idle after reset
        for (int e = 0; e < 20; e++) step('0);
        check_int("idle_pulses", pulse_seen[0] + pulse_seen[4], 0);

        // Clean press on bit 0: pulse right after edge 7, only once while held
        clear_counts();
        first_edge = -1;
        for (int e = 1; e <= 57; e++) begin
            step(5'b00001);
            if (btn_pulse[0] && first_edge < 0) first_edge = e;
        end
        check_int("clean_press_edge", first_edge, DC + 3);
        check_int("clean_press_count", pulse_seen[0], 1);

        // Release bounce: short drop, re-press inside RELEASE_WAIT, then real release
        clear_counts();
        step(5'b00000); step(5'b00000); step(5'b00000);
        step(5'b00001); step(5'b00001);
        for (int e = 0; e < 10; e++) step(5'b00001);
        check_int("release_bounce_none", rel_seen[0], 0);
        first_edge = -1;
        for (int e = 1; e <= 20; e++) begin
            step(5'b00000);
            if (btn_release[0] && first_edge < 0) first_edge = e;
        end
        check_int("release_edge", first_edge, DC + 3);
        check_int("release_count", rel_seen[0], 1);

        // Bouncy press on bit 2
        clear_counts();
        step(5'b00100); step(5'b00000); step(5'b00100);
        step(5'b00100); step(5'b00000); step(5'b00100);
        check_int("bouncy_no_early", pulse_seen[2], 0);
        for (int e = 0; e < 20; e++) step(5'b00100);
        check_int("bouncy_once", pulse_seen[2], 1);
        for (int e = 0; e < 12; e++) step(5'b00000);

        // Simultaneous buttons
        clear_counts();
        first_edge = -1;
        for (int e = 1; e <= 12; e++) begin
            step(5'b10011);
            if (btn_pulse != '0 && first_edge < 0) begin
                first_edge = e;
                check_vec("simul_pulse", btn_pulse, 5'b10011);
            end
        end
        check_int("simul_edge", first_edge, DC + 3);
        for (int e = 0; e < 12; e++) step(5'b00000);

        // Reset mid-debounce on bit 4
        clear_counts();
        step(5'b10000); step(5'b10000); step(5'b10000);
        btn_raw = 5'b10000;
        do_reset();
        check_int("mid_rst_no_pulse", pulse_seen[4], 0);
        first_edge = -1;
        for (int e = 1; e <= 15; e++) begin
            step(5'b10000);
            if (btn_pulse[4] && first_edge < 0) first_edge = e;
        end
        check_int("mid_rst_restart_edge", first_edge, DC + 3);
        for (int e = 0; e < 12; e++) step(5'b00000);

        // Random bouncing with mixed short and long holds
        rnd_raw = '0;
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int e = 0; e < 2000; e++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    rnd_raw[i] = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 20))
                                                          : int'($urandom_range(1, 4));
                end
                hold[i]--;
            end
            if ($urandom_range(0, 499) == 0) begin
                btn_raw = rnd_raw;
                do_reset();
            end else begin
                step(rnd_raw);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
